// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Program counter owner and req/ack instruction fetcher; holds each
//            fetched word until commit, then selects sequential/branch/jump PC.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        pcsrc,
    input  logic        jump,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] retired_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retired_q, retired_d;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_off;
    logic [31:0] w_next_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= 32'h0000_0000;
            retired_q <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

    assign w_pc_plus4   = pc_q + 32'd4;
    assign w_branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    // Jump outranks a taken branch when the controller raises both.
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (jump) begin
            w_next_pc = {w_pc_plus4[31:28], instr_q[25:0], 2'b00};
        end else if (pcsrc) begin
            w_next_pc = w_pc_plus4 + w_branch_off;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    pc_d      = w_next_pc;
                    retired_d = retired_q + 32'd1;
                    state_d   = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign imem_req      = (state_q == S_FETCH);
    assign imem_addr     = pc_q;
    assign instr         = instr_q;
    assign instr_valid   = (state_q == S_HOLD);
    assign pc            = pc_q;
    assign pc_plus4      = w_pc_plus4;
    assign retired_count = retired_q;

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Sequential instruction fetch unit that supplies the 32-bit `instr` word consumed by the single-cycle controller and closes the loop on its `PCSRC` and `jump` decisions. It owns the program counter and issues requests to instruction memory over a req/ack handshake that tolerates variable latency. It holds each fetched instruction stable until the datapath commits it, then computes the next PC as sequential, branch or jump.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset. Must be word aligned.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `imem_req`  out  1: fetch request to instruction memory.
- `imem_addr`  out  32: fetch address. Always equals `pc`.
- `imem_ack`  in  1: memory response valid. Sampled only while `imem_req`=1.
- `imem_rdata`  in  32: instruction word. Valid when `imem_ack`=1.
- `instr`  out  32: registered instruction presented to the controller.
- `instr_valid`  out  1: `instr` holds a fetched, uncommitted instruction.
- `instr_ready`  in  1: datapath commits `instr` this cycle.
- `pcsrc`  in  1: controller branch-taken (branch AND zero) for the current `instr`.
- `jump`  in  1: controller jump for the current `instr`.
- `pc`  out  32: address of the current `instr`.
- `pc_plus4`  out  32: `pc`+4, modulo 2^32.
- `retired_count`  out  32: number of committed instructions, wraps at 2^32.

## Operation
- FSM has three states: IDLE, FETCH and HOLD.
- IDLE:
  - Entered on any cycle with `rst`=1.
  - Goes to FETCH unconditionally on the next edge with `rst`=0.
- FETCH:
  - `imem_req`=1 combinationally.
  - `imem_addr`=`pc`, held stable until ack.
  - On an edge with `imem_ack`=1: `instr`<=`imem_rdata`, go to HOLD.
  - Without ack: remain in FETCH, request held.
- HOLD:
  - `instr_valid`=1, `imem_req`=0.
  - `instr` and `pc` stay frozen while `instr_ready`=0.
  - On an edge with `instr_ready`=1:
    - `pc`<=next_pc.
    - `retired_count`+=1.
    - Go to FETCH.
- next_pc priority:
  1. `jump`=1: {`pc_plus4`[31:28], `instr`[25:0], 2'b00}.
  2. else `pcsrc`=1: `pc_plus4` + (sign-extend(`instr`[15:0]) << 2). This is a 32-bit add with carry discarded (wraps).
  3. else `pc_plus4`.
- `pcsrc`, `jump` and `instr_ready` are ignored outside HOLD.
- `imem_ack` is ignored while `imem_req`=0.
- `instr_valid` is 0 in IDLE and FETCH.
- `instr` retains its last value outside HOLD; it is not cleared on commit.

## Timing
- Reset values, applied on an edge with `rst`=1, overriding all other activity:
  - `pc`=RESET_PC, `pc_plus4`=RESET_PC+4.
  - `instr`=0, `instr_valid`=0, `imem_req`=0, `retired_count`=0.
  - state=IDLE.
- First request: `imem_req` rises in the first cycle after `rst` deasserts (IDLE → FETCH edge).
- Zero-wait memory: ack in the same cycle `imem_req` rises. `instr_valid`=1 the next cycle.
- Minimum commit rate is one instruction per 2 cycles (FETCH, HOLD). Each wait cycle from memory adds one cycle.
- A commit is the edge where `instr_valid`=1 and `instr_ready`=1. The new `pc` is visible and `imem_req`=1 from the following cycle.
- Reset mid-fetch (FETCH with ack pending): the request is abandoned. `imem_req` drops the cycle after the `rst` edge. A late ack is ignored.
- Reset in HOLD: the instruction is discarded without commit and `retired_count` is not incremented.
- `jump` and `pcsrc` both 1: the jump wins.
- `pc`=32'hFFFF_FFFC: `pc_plus4`=0, and a sequential commit wraps `pc` to 0.
- `retired_count`=32'hFFFF_FFFF plus one commit gives 0.

## Test plan
- Reset with RESET_PC=0, zero-wait memory returning `imem_rdata`=32'h2008_0005:
  - Cycle 1 after reset: `imem_req`=1, `imem_addr`=0.
  - Cycle 2: `instr`=32'h2008_0005, `instr_valid`=1.
  - Commit with `instr_ready`=1: `pc`=4, `retired_count`=1.
- Memory delays ack 3 cycles: `imem_req` held high and `imem_addr` stable for 4 cycles, `instr_valid`=0 throughout; the word is latched on the ack edge.
- Branch at `pc`=32'h0000_0010 with `instr`[15:0]=16'hFFFE, `pcsrc`=1, commit → `pc`=32'h0000_000C. With `pcsrc`=0 → `pc`=32'h0000_0014.
- Jump at `pc`=32'h4000_0000 with `instr`=32'h0800_0040 and both `jump`=1 and `pcsrc`=1 → `pc`=32'h4000_0100.
- `instr_ready` held 0 for 5 cycles in HOLD: `instr`, `pc` and `instr_valid`=1 unchanged, `imem_req`=0, `retired_count` unchanged.
- Assert `rst` while FETCH waits for ack, then ack one cycle later:
  - `pc`=RESET_PC, `imem_req`=0 and `instr_valid`=0 after the reset edge.
  - The late ack does not load `instr`.
  - Fetching restarts from RESET_PC.
